// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, payload width and line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Line levels for the frame delimiters.
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    // PARITY keeps its code even when the parity bit is not built in, so the
    // encoding seen on a debug bus is the same in every build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side byte-write handshake into the UART transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: host may only write while Tx_BUSY is low; writes made while busy are dropped.
// Signals: Tx_WR (write strobe), Tx_DATA (byte), Tx_BUSY (frame pending/on line),
//          Tx_DONE (one-cycle pulse when the stop bit completes).
interface uart_transmitter_if #(
    parameter int DATA_W = uart_pkg::UART_DATA_W
) ();

    logic              Tx_WR;
    logic [DATA_W-1:0] Tx_DATA;
    logic              Tx_BUSY;
    logic              Tx_DONE;

    modport master (
        output Tx_WR,
        output Tx_DATA,
        input  Tx_BUSY,
        input  Tx_DONE
    );

    modport slave (
        input  Tx_WR,
        input  Tx_DATA,
        output Tx_BUSY,
        output Tx_DONE
    );

endinterface

// File: rtl/uart_tx_shifter.sv
// Payload datapath for the UART transmitter: load/shift register, bit counter, parity.
// Latency: load/shift/clear take effect on the next clk edge.
// Backpressure: none; driven purely by the transmitter FSM controls.
// Ports: clk, reset (sync, active-low); i_load/i_shift/i_clear controls; i_data byte;
//        o_bit0/o_bit1 current and next payload bit; o_last counter at final bit;
//        o_parity (UART_TX_PARITY_EN builds only) even parity of the loaded byte.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_bit0,
    output logic              o_bit1,
`ifdef UART_TX_PARITY_EN
    output logic              o_parity,
`endif
    output logic              o_last
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;
`ifdef UART_TX_PARITY_EN
    // Captured at load time because the byte is shifted away while it is sent.
    logic              r_parity;
`endif

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (i_load) begin
            r_shreg  <= i_data;
            r_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^i_data;
`endif
        end else if (i_shift) begin
            r_shreg  <= {1'b0, r_shreg[DATA_W-1:1]};
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_bit0   = r_shreg[0];
    // The FSM registers the next bit onto the line on the same edge it shifts.
    assign o_bit1   = r_shreg[1];
    assign o_last   = (r_cnt == CNT_W'(DATA_W - 1));
`ifdef UART_TX_PARITY_EN
    assign o_parity = r_parity;
`endif

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per write, one bit per Tx_sample_ENABLE tick, LSB first.
// Latency: start bit on the first tick edge after the accepting edge; Tx_DONE 10 ticks
//          later (11 with the parity bit). Backpressure: Tx_BUSY high rejects writes.
// Ports: clk, reset (sync, active-low); Tx_EN (low aborts to idle); Tx_sample_ENABLE
//        (bit tick); tx_if (Tx_WR/Tx_DATA in, Tx_BUSY/Tx_DONE out); TxD registered line.
// Build option: define UART_TX_PARITY_EN to send an even-parity bit after bit 7.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Tx_EN,
    input  logic                Tx_sample_ENABLE,
    uart_transmitter_if.slave   tx_if,
    output logic                TxD
);

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        w_load;
    logic        w_shift;
    logic        w_clear;
    logic        w_bit0;
    logic        w_bit1;
    logic        w_last;
`ifdef UART_TX_PARITY_EN
    logic        w_parity;
`endif

    uart_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_clear  (w_clear),
        .i_data   (tx_if.Tx_DATA),
        .o_bit0   (w_bit0),
        .o_bit1   (w_bit1),
`ifdef UART_TX_PARITY_EN
        .o_parity (w_parity),
`endif
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_txd   <= UART_STOP_BIT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_txd_nxt   = r_txd;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;

        if (!Tx_EN) begin
            // Abort: drop the byte, release the line, no completion pulse.
            w_state_nxt = IDLE;
            w_txd_nxt   = UART_STOP_BIT;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_txd_nxt = UART_STOP_BIT;
                    // Ticks here are ignored: SYNC waits for the next one so the
                    // start bit lasts a full tick period.
                    if (tx_if.Tx_WR) begin
                        w_load      = 1'b1;
                        w_state_nxt = SYNC;
                    end
                end
                SYNC: if (Tx_sample_ENABLE) begin
                    w_state_nxt = START;
                    w_txd_nxt   = UART_START_BIT;
                end
                START: if (Tx_sample_ENABLE) begin
                    w_state_nxt = DATA;
                    w_txd_nxt   = w_bit0;
                end
                DATA: if (Tx_sample_ENABLE) begin
                    if (!w_last) begin
                        w_shift   = 1'b1;
                        w_txd_nxt = w_bit1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = PARITY;
                        w_txd_nxt   = w_parity;
`else
                        w_state_nxt = STOP;
                        w_txd_nxt   = UART_STOP_BIT;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (Tx_sample_ENABLE) begin
                    w_state_nxt = STOP;
                    w_txd_nxt   = UART_STOP_BIT;
                end
`endif
                STOP: if (Tx_sample_ENABLE) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_txd_nxt   = UART_STOP_BIT;
                end
            endcase
        end
    end

    assign TxD           = r_txd;
    // Derived from the state register, so it rises on the accepting edge and
    // falls on the edge leaving STOP together with Tx_DONE.
    assign tx_if.Tx_BUSY = (r_state != IDLE);
    assign tx_if.Tx_DONE = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a bit tick every 16 clocks.
// Latency: n/a. Backpressure: n/a.
// Line is sampled at mid-bit on falling clk edges against hand-built frames.
`timescale 1ns/1ps
module tb_uart_transmitter;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       Tx_EN = 1'b0;
    logic       TxD;
    logic [3:0] tcnt  = 4'd0;
    logic       tick;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    uart_transmitter_if #(.DATA_W(UART_DATA_W)) tx_if ();

    uart_transmitter #(.DATA_W(UART_DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .Tx_EN            (Tx_EN),
        .Tx_sample_ENABLE (tick),
        .tx_if            (tx_if),
        .TxD              (TxD)
    );

    always #10 clk = ~clk;

    always @(posedge clk) tcnt <= tcnt + 4'd1;
    assign tick = (tcnt == 4'd15);

    always @(posedge clk) if (tx_if.Tx_DONE === 1'b1) done_cnt++;

    // Bit i of the result is the line level during the i-th tick period.
    function automatic logic [NBITS-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic send_write(input logic [7:0] d);
        tx_if.Tx_WR   = 1'b1;
        tx_if.Tx_DATA = d;
        @(negedge clk);
        tx_if.Tx_WR   = 1'b0;
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (TxD === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_start: TxD stayed %b for 40 cycles, required 0", name, TxD);
        end
    endtask

    // Called on the first falling edge after the start-bit edge; returns on the
    // falling edge where Tx_DONE is high.
    task automatic check_frame(input string name, input logic [7:0] d, input bit mid_wr);
        logic [NBITS-1:0] exp;
        int el;
        exp = frame_of(d);
        el  = 0;
        for (int i = 0; i < NBITS; i++) begin
            while (el < 8 + 16 * i) begin @(negedge clk); el++; end
            checks++;
            if (TxD !== exp[i]) begin
                failures++;
                $display("FAIL %s_bit%0d: TxD=%b required %b", name, i, TxD, exp[i]);
            end
            if (mid_wr && i == 4) begin
                tx_if.Tx_WR   = 1'b1;
                tx_if.Tx_DATA = 8'hA3;
                @(negedge clk); el++;
                tx_if.Tx_WR   = 1'b0;
                checks++;
                if (tx_if.Tx_BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_busy_midwr: Tx_BUSY=%b required 1", name, tx_if.Tx_BUSY);
                end
            end
        end
        while (el < 16 * NBITS - 1) begin @(negedge clk); el++; end
        checks++;
        if (tx_if.Tx_DONE !== 1'b0 || tx_if.Tx_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL %s_pre_done: DONE=%b BUSY=%b required 0 1", name, tx_if.Tx_DONE, tx_if.Tx_BUSY);
        end
        @(negedge clk);
        checks++;
        if (tx_if.Tx_DONE !== 1'b1 || tx_if.Tx_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: DONE=%b BUSY=%b required 1 0", name, tx_if.Tx_DONE, tx_if.Tx_BUSY);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        Tx_EN = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (TxD !== 1'b1) begin failures++; $display("FAIL reset_txd: TxD=%b required 1", TxD); end
        checks++;
        if (tx_if.Tx_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: Tx_BUSY=%b required 0", tx_if.Tx_BUSY); end
        checks++;
        if (tx_if.Tx_DONE !== 1'b0) begin failures++; $display("FAIL reset_done: Tx_DONE=%b required 0", tx_if.Tx_DONE); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame(input string name, input logic [7:0] d);
        bit ok;
        int d0;
        d0 = done_cnt;
        send_write(d);
        checks++;
        if (tx_if.Tx_BUSY !== 1'b1) begin failures++; $display("FAIL %s_accept: Tx_BUSY=%b required 1", name, tx_if.Tx_BUSY); end
        wait_start(name, ok);
        if (ok) begin
            check_frame(name, d, 1'b0);
            @(negedge clk);
            checks++;
            if (tx_if.Tx_DONE !== 1'b0) begin failures++; $display("FAIL %s_done_width: Tx_DONE=%b required 0", name, tx_if.Tx_DONE); end
            @(negedge clk);
            checks++;
            if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done_count: pulses=%0d required 1", name, done_cnt - d0); end
        end
    endtask

    task automatic test_tick_on_accept();
        bit hi_ok;
        for (int n = 0; n < 20 && tick !== 1'b1; n++) @(negedge clk);
        send_write(8'hC6);
        hi_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (TxD !== 1'b1) hi_ok = 1'b0;
        end
        checks++;
        if (!hi_ok) begin failures++; $display("FAIL tickacc_early: TxD low before next tick, required high"); end
        @(negedge clk);
        checks++;
        if (TxD !== 1'b0) begin
            failures++;
            $display("FAIL tickacc_start: TxD=%b required 0", TxD);
        end else begin
            check_frame("tickacc", 8'hC6, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_mid_frame();
        bit ok;
        bit idle_ok;
        send_write(8'h55);
        wait_start("ignore", ok);
        if (ok) begin
            check_frame("ignore", 8'h55, 1'b1);
            idle_ok = 1'b1;
            repeat (48) begin
                @(negedge clk);
                if (TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0) idle_ok = 1'b0;
            end
            checks++;
            if (!idle_ok) begin failures++; $display("FAIL ignore_no_second: line active after frame, required idle"); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit idle_ok;
        int d0;
        send_write(8'h0F);
        wait_start("abort", ok);
        if (ok) begin
            repeat (72) @(negedge clk);
            d0    = done_cnt;
            Tx_EN = 1'b0;
            @(negedge clk);
            checks++;
            if (TxD !== 1'b1) begin failures++; $display("FAIL abort_txd: TxD=%b required 1", TxD); end
            checks++;
            if (tx_if.Tx_BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy: Tx_BUSY=%b required 0", tx_if.Tx_BUSY); end
            idle_ok = 1'b1;
            repeat (100) begin
                @(negedge clk);
                if (TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0) idle_ok = 1'b0;
            end
            checks++;
            if (!idle_ok) begin failures++; $display("FAIL abort_idle: line active while disabled, required idle"); end
            checks++;
            if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done: pulses=%0d required 0", done_cnt - d0); end
            Tx_EN = 1'b1;
            @(negedge clk);
            test_single_frame("abort_rerun", 8'h0F);
        end
    endtask

    task automatic test_write_disabled();
        bit idle_ok;
        Tx_EN         = 1'b0;
        tx_if.Tx_WR   = 1'b1;
        tx_if.Tx_DATA = 8'h3C;
        @(negedge clk);
        tx_if.Tx_WR   = 1'b0;
        Tx_EN         = 1'b1;
        checks++;
        if (tx_if.Tx_BUSY !== 1'b0) begin failures++; $display("FAIL wr_disabled_busy: Tx_BUSY=%b required 0", tx_if.Tx_BUSY); end
        idle_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0) idle_ok = 1'b0;
        end
        checks++;
        if (!idle_ok) begin failures++; $display("FAIL wr_disabled_idle: line active, required idle"); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit idle_ok;
        send_write(8'h55);
        wait_start("rstmid", ok);
        if (ok) begin
            repeat (8) @(negedge clk);
            checks++;
            if (TxD !== 1'b0) begin failures++; $display("FAIL rstmid_pre: TxD=%b required 0", TxD); end
            reset = 1'b0;
            @(negedge clk);
            checks++;
            if (TxD !== 1'b1) begin failures++; $display("FAIL rstmid_txd: TxD=%b required 1", TxD); end
            checks++;
            if (tx_if.Tx_BUSY !== 1'b0) begin failures++; $display("FAIL rstmid_busy: Tx_BUSY=%b required 0", tx_if.Tx_BUSY); end
            checks++;
            if (tx_if.Tx_DONE !== 1'b0) begin failures++; $display("FAIL rstmid_done: Tx_DONE=%b required 0", tx_if.Tx_DONE); end
            repeat (2) @(negedge clk);
            reset = 1'b1;
            idle_ok = 1'b1;
            repeat (64) begin
                @(negedge clk);
                if (TxD !== 1'b1 || tx_if.Tx_BUSY !== 1'b0) idle_ok = 1'b0;
            end
            checks++;
            if (!idle_ok) begin failures++; $display("FAIL rstmid_idle_ticks: line active in idle, required idle"); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit hi_ok;
        send_write(8'h12);
        wait_start("b2b_first", ok);
        if (ok) begin
            check_frame("b2b_first", 8'h12, 1'b0);
            send_write(8'h34);
            checks++;
            if (tx_if.Tx_BUSY !== 1'b1) begin failures++; $display("FAIL b2b_accept: Tx_BUSY=%b required 1", tx_if.Tx_BUSY); end
            hi_ok = 1'b1;
            repeat (14) begin
                @(negedge clk);
                if (TxD !== 1'b1) hi_ok = 1'b0;
            end
            checks++;
            if (!hi_ok) begin failures++; $display("FAIL b2b_gap: TxD low before next tick, required high"); end
            @(negedge clk);
            checks++;
            if (TxD !== 1'b0) begin
                failures++;
                $display("FAIL b2b_second_start: TxD=%b required 0", TxD);
            end else begin
                check_frame("b2b_second", 8'h34, 1'b0);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        tx_if.Tx_WR   = 1'b0;
        tx_if.Tx_DATA = 8'h00;
        test_reset();
        test_single_frame("f55", 8'h55);
        test_single_frame("f01", 8'h01);
        test_tick_on_accept();
        test_ignore_mid_frame();
        test_abort();
        test_write_disabled();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
